// File: rtl/comparator_seq_nib.sv
// Sequential nibble-serial magnitude comparator.
// Captures two unsigned operands and compares them one nibble per cycle,
// most significant nibble first, stopping at the first nibble that differs.
// The result flags and the count of examined nibbles hold until the next result.
module comparator_seq_nib #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] A,
  input  logic [4*NIB-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Gt,
  output logic             Sm,
  output logic [3:0]       nib_used
);

  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4*NIB-1:0]  a_q, a_d;
  logic [4*NIB-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              eq_q, eq_d;
  logic              gt_q, gt_d;
  logic              sm_q, sm_d;
  logic [3:0]        used_q, used_d;

  // Captured operands split into nibble lanes so the active lane is a plain index.
  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_lane
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  logic [3:0] cur_a, cur_b;
  logic       nib_eq, nib_gt;

  assign cur_a  = a_nib[idx_q];
  assign cur_b  = b_nib[idx_q];
  assign nib_eq = (cur_a == cur_b);
  assign nib_gt = (cur_a > cur_b);

  // State, operand capture, index and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      sm_q    <= 1'b0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      sm_q    <= sm_d;
      used_q  <= used_d;
    end
  end

  // Next-state logic: capture in IDLE, walk nibbles in CMP, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    sm_d    = sm_q;
    used_d  = used_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IDXW'(NIB - 1);
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (!nib_eq) begin
          // First differing nibble decides the whole comparison.
          eq_d    = 1'b0;
          gt_d    = nib_gt;
          sm_d    = !nib_gt;
          used_d  = 4'(NIB) - 4'(idx_q);
          state_d = S_DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          sm_d    = 1'b0;
          used_d  = 4'(NIB);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_CMP);
  assign done     = (state_q == S_DONE);
  assign Eq       = eq_q;
  assign Gt       = gt_q;
  assign Sm       = sm_q;
  assign nib_used = used_q;

endmodule

// File: tb/tb_comparator_seq_nib.sv
// Self-checking bench for comparator_seq_nib (NIB=4) with a whole-number reference model.
module tb_comparator_seq_nib;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, Eq, Gt, Sm;
  logic [3:0]  nib_used;

  int n_checks = 0;
  int n_pass   = 0;

  // Model's record of the last completed result.
  logic       m_eq = 1'b0, m_gt = 1'b0, m_sm = 1'b0;
  logic [3:0] m_used = 4'd0;

  comparator_seq_nib #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Eq(Eq), .Gt(Gt), .Sm(Sm), .nib_used(nib_used)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: nibbles examined = length of the equal high-order prefix plus one, capped at NIB.
  task automatic model(input logic [15:0] a, input logic [15:0] b);
    int k;
    k = 0;
    for (int n = NIB - 1; n >= 0; n--) begin
      k++;
      if (((a >> (4 * n)) & 16'hF) != ((b >> (4 * n)) & 16'hF)) break;
    end
    m_used = 4'(k);
    m_eq   = (a == b);
    m_gt   = (a > b);
    m_sm   = (a < b);
  endtask

  task automatic check_result(input string tag);
    check({tag, ".Eq"}, 32'(Eq), 32'(m_eq));
    check({tag, ".Gt"}, 32'(Gt), 32'(m_gt));
    check({tag, ".Sm"}, 32'(Sm), 32'(m_sm));
    check({tag, ".used"}, 32'(nib_used), 32'(m_used));
  endtask

  // One full transaction with cycle-exact busy/done checking.
  task automatic do_cmp(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic p_eq, p_gt, p_sm;
    logic [3:0] p_used;
    p_eq = m_eq; p_gt = m_gt; p_sm = m_sm; p_used = m_used;
    model(a, b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = a;
    // Previous result must hold during the first CMP cycle.
    check({tag, ".hold"}, {28'(p_used), p_eq, p_gt, p_sm, 1'b0},
          {28'(nib_used), Eq, Gt, Sm, 1'b0});
    for (int i = 0; i < int'(m_used); i++) begin
      check({tag, ".busy"}, {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
      @(negedge clk);
    end
    check({tag, ".done"}, {30'd0, busy, done}, {30'd0, 1'b0, 1'b1});
    check_result(tag);
    @(negedge clk);
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    $display("cmp %s A=%h B=%h -> Eq=%b Gt=%b Sm=%b used=%0d", tag, a, b, Eq, Gt, Sm, nib_used);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int pulses, waited;

    // Reset state.
    #2;
    check("rst.outs", {26'd0, busy, done, Eq, Gt, Sm, 1'b0} | 32'(nib_used), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.hold", {26'd0, busy, done, Eq, Gt, Sm, 1'b0} | 32'(nib_used), 32'd0);

    // Directed cases.
    do_cmp("eq1234", 16'h1234, 16'h1234);
    do_cmp("gt8000", 16'h8000, 16'h7FFF);
    do_cmp("sm12A3", 16'h12A3, 16'h12A4);
    do_cmp("gt1300", 16'h1300, 16'h12FF);

    // Operand change and second start during CMP are ignored.
    model(16'h0001, 16'h0000);
    @(negedge clk);
    A = 16'h0001; B = 16'h0000; start = 1'b1;
    @(negedge clk);
    A = 16'h0000; B = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ign.done", 32'(done), 32'd1);
    check_result("ign");
    $display("cmp ign A=0001 B=0000 -> Eq=%b Gt=%b Sm=%b used=%0d", Eq, Gt, Sm, nib_used);
    @(negedge clk);

    // Reset during CMP aborts asynchronously with no done pulse.
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort.busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort.outs", {26'd0, busy, done, Eq, Gt, Sm, 1'b0} | 32'(nib_used), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort.nodone", 32'(pulses), 32'd0);
    m_eq = 1'b0; m_gt = 1'b0; m_sm = 1'b0; m_used = 4'd0;
    do_cmp("eq0", 16'h0000, 16'h0000);

    // start held high: a result every 3 cycles.
    model(16'h5000, 16'h4000);
    @(negedge clk);
    A = 16'h5000; B = 16'h4000; start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("b2b.done", 32'(done), 32'((i % 3) == 2));
      if (done) begin
        pulses++;
        check_result("b2b");
        $display("b2b pulse %0d at cycle %0d Gt=%b used=%0d", pulses, i, Gt, nib_used);
      end
    end
    start = 1'b0;
    check("b2b.count", 32'(pulses), 32'd7);
    repeat (2) @(negedge clk);

    // Randomized: B shares a random-length high prefix with A.
    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: rb = {ra[15:4], rb[3:0]};
        2: rb = {ra[15:8], rb[7:0]};
        3: rb = {ra[15:12], rb[11:0]};
        default: ;
      endcase
      do_cmp($sformatf("rnd%0d", t), ra, rb);
      check("rnd.onehot", 32'(Eq) + 32'(Gt) + 32'(Sm), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/comparator_seq_nib.md
COMPARATOR_SEQ_NIB -- requirements
Module: comparator_seq_nib

Interface
REQ-001 SHALL have parameter NIB, default 4, meaning number of 4-bit nibbles per operand (operand width 4*NIB; legal range 1..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to compare A and B; sampled only in IDLE.
REQ-005 SHALL have port A  input  4*NIB  first operand, unsigned.
REQ-006 SHALL have port B  input  4*NIB  second operand, unsigned.
REQ-007 SHALL have port busy  output  1  high while a comparison is in progress (state CMP).
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid and new in this cycle.
REQ-009 SHALL have port Eq  output  1  last result: A == B.
REQ-010 SHALL have port Gt  output  1  last result: A > B.
REQ-011 SHALL have port Sm  output  1  last result: A < B.
REQ-012 SHALL have port nib_used  output  4  number of nibbles examined for last result (1..NIB).

Function
REQ-013 SHALL implement FSM with states IDLE, CMP, DONE; all outputs registered.
REQ-014 IDLE: start=1 at a rising edge SHALL capture A and B into internal registers, load nibble index = NIB-1, and enter CMP.
REQ-015 start SHALL be ignored in CMP and DONE; operand inputs SHALL be ignored except at the capture edge.
REQ-016 CMP: each edge SHALL compare captured nibble [index] of A vs B, MSB nibble first, using per-nibble equal/greater/smaller logic.
REQ-017 CMP, nibbles unequal: SHALL set Gt or Sm (per nibble result), clear the other two flags, and enter DONE at that edge (early termination).
REQ-018 CMP, nibbles equal and index > 0: SHALL decrement index and remain in CMP.
REQ-019 CMP, nibbles equal and index == 0: SHALL set Eq=1, Gt=0, Sm=0 and enter DONE.
REQ-020 nib_used SHALL be updated at the same edge as Eq/Gt/Sm, equal to count of nibbles examined.
REQ-021 DONE: done=1 for exactly one cycle; next edge SHALL return to IDLE unconditionally.
REQ-022 Latency: if start captured at edge e0 and k nibbles examined, done SHALL be high in the cycle following edge e0+k; k=1 minimum, k=NIB for equal operands.
REQ-023 busy SHALL be 1 exactly in CMP cycles (k cycles per comparison); busy and done SHALL never be high together.
REQ-024 Eq/Gt/Sm/nib_used SHALL hold their last result through IDLE and the next CMP until overwritten at the next result edge.
REQ-025 After the first completed comparison exactly one of Eq, Gt, Sm SHALL be 1 at all times.
REQ-026 start held high continuously SHALL cause back-to-back comparisons: a new capture on the IDLE cycle following each DONE.
REQ-027 Operands SHALL be treated unsigned; no carry or arithmetic beyond per-nibble magnitude compare.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, Eq=0, Gt=0, Sm=0, nib_used=0, captured operands and index to 0.
REQ-029 rst asserted during CMP or DONE SHALL abort the comparison with no done pulse; the first start after rst deassertion SHALL be handled normally.
REQ-030 start coinciding with the edge on which rst deasserts SHALL not be captured; capture begins at the next edge.

Verification
REQ-031 NIB=4, A=16'h1234, B=16'h1234, start one cycle -> busy 4 cycles, done in cycle after edge e0+4, Eq=1, Gt=0, Sm=0, nib_used=4.
REQ-032 A=16'h8000, B=16'h7FFF -> busy 1 cycle, done after edge e0+1, Gt=1, nib_used=1.
REQ-033 A=16'h12A3, B=16'h12A4 -> done after edge e0+4, Sm=1, nib_used=4; then A=16'h1300, B=16'h12FF -> Gt=1, nib_used=2.
REQ-034 start at e0 with A=16'h0001,B=16'h0000; at e0+1 change A=16'h0000,B=16'hFFFF and pulse start -> second start ignored, result Gt=1, nib_used=4.
REQ-035 rst pulse during CMP of A=16'hFFFF, B=16'hFFFF -> all outputs 0 immediately, no done; subsequent start with A=0,B=0 -> Eq=1, nib_used=4.
REQ-036 start held high for 20 cycles with A=16'h5000, B=16'h4000 -> done pulses every 3 cycles (IDLE, CMP, DONE), each with Gt=1, nib_used=1.
